prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/prog_loader.sv | 135 +++++++++++++
 tb/tb_prog_loader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared constants and state encoding for the program loader.
//   BYTE_W  : width of one stream byte
//   state_e : loader FSM state encoding
package prog_loader_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_e;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: receives a byte stream [count, (hi, lo) x N, xor checksum],
// writes each word into program memory and releases the CPU from reset only
// when the checksum matches.
//
// Ports
//   clk, rst            clock, async active-low reset
//   start               arms a load (from IDLE, DONE or ERROR only)
//   in_valid/in_data    byte-stream source
//   in_ready            loader accepts a byte this cycle
//   mem_we/addr/wdata   program-memory write port (combinational on LO handshake)
//   cpu_hold            holds the CPU in reset while 1
//   done / err          load finished with good / bad checksum
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_COUNT | expecting word-count byte (0 = full memory depth)
// ST_HI    | expecting high byte of next word
// ST_LO    | expecting low byte; write issued on its handshake
// ST_CHECK | expecting checksum byte
// ST_DONE  | load good, CPU released
// ST_ERROR | checksum bad, CPU held
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [BYTE_W-1:0]  in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               err
);

    // One extra bit so the counter can hold the full depth 2**ADDR_W.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [BYTE_W-1:0]   xor_q,   xor_d;
    logic [BYTE_W-1:0]   hi_q,    hi_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            xor_q   <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            xor_q   <= xor_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        xor_d     = xor_q;
        hi_d      = hi_q;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        cpu_hold  = 1'b1;
        done      = 1'b0;
        err       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_COUNT;
            end
            ST_COUNT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_d   = (in_data == '0) ? CNT_FULL : CNT_W'(in_data);
                    addr_d  = '0;
                    xor_d   = '0;
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    hi_d    = in_data;
                    xor_d   = xor_q ^ in_data;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = INSTR_W'({hi_q, in_data});
                    addr_d    = addr_q + 1'b1;
                    cnt_d     = cnt_q - 1'b1;
                    xor_d     = xor_q ^ in_data;
                    state_d   = (cnt_q == CNT_W'(1)) ? ST_CHECK : ST_HI;
                end
            end
            ST_CHECK: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (in_data == xor_q) ? ST_DONE : ST_ERROR;
                end
            end
            ST_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
                if (start) state_d = ST_COUNT;
            end
            ST_ERROR: begin
                err = 1'b1;
                if (start) state_d = ST_COUNT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_addr = addr_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed checks of prog_loader with hand-computed vectors.
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0]  wr_a[$];
    logic [15:0] wr_d[$];

    prog_loader #(.ADDR_W(8), .INSTR_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at posedge+2, so mem_we at the negedge reflects the
    // handshake that completes on the following rising edge.
    always @(negedge clk) begin
        if (rst && mem_we) begin
            wr_a.push_back(mem_addr);
            wr_d.push_back(mem_wdata);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Called at posedge+2; returns at posedge+2 after the byte is accepted.
    task automatic send(input logic [7:0] b, input bit stall);
        int g;
        if (stall) begin
            in_valid = 1'b0;
            @(posedge clk); #2;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    // start_at: index of the byte during which start is held high (-1 none).
    task automatic run_load(input logic [7:0] q[$], input bit stall, input int start_at);
        pulse_start();
        foreach (q[i]) begin
            start = (i == start_at);
            send(q[i], stall);
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input logic d, input logic e, input logic h);
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_err"},  32'(err),  32'(e));
        chk({tag, "_hold"}, 32'(cpu_hold), 32'(h));
        chk({tag, "_rdy"},  32'(in_ready), 32'd0);
    endtask

    task automatic chk_two_words(input string tag);
        chk({tag, "_nwr"}, 32'(wr_a.size()), 32'd2);
        if (wr_a.size() == 2) begin
            chk({tag, "_a0"}, 32'(wr_a[0]), 32'h00);
            chk({tag, "_d0"}, 32'(wr_d[0]), 32'h1234);
            chk({tag, "_a1"}, 32'(wr_a[1]), 32'h01);
            chk({tag, "_d1"}, 32'(wr_d[1]), 32'hABCD);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdy"},   32'(in_ready),  32'd0);
        chk({tag, "_we"},    32'(mem_we),    32'd0);
        chk({tag, "_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_hold"},  32'(cpu_hold),  32'd1);
        chk({tag, "_done"},  32'(done),      32'd0);
        chk({tag, "_err"},   32'(err),       32'd0);
    endtask

    logic [7:0] good_q[$];
    logic [7:0] bad_q[$];
    logic [7:0] part_q[$];
    logic [7:0] full_q[$];
    logic [7:0] hi_b, lo_b, x;

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        // 12^34^AB^CD = 40
        good_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        bad_q  = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00};
        part_q = '{8'h02, 8'h12, 8'h34, 8'hAB};
        #1;
        chk_reset_outputs("rst0");

        @(negedge clk); rst = 1'b1;
        @(posedge clk); #2;
        chk("idle_hold", 32'(cpu_hold), 32'd1);
        chk("idle_rdy",  32'(in_ready), 32'd0);

        // Good two-word load.
        wr_a.delete(); wr_d.delete();
        run_load(good_q, 1'b0, -1);
        chk_two_words("good");
        chk_flags("good", 1'b1, 1'b0, 1'b0);

        // Start from DONE: flags clear and hold reasserts next cycle.
        pulse_start();
        chk("rearm_done", 32'(done), 32'd0);
        chk("rearm_hold", 32'(cpu_hold), 32'd1);
        chk("rearm_rdy",  32'(in_ready), 32'd1);
        @(negedge clk); rst = 1'b0; #1; rst = 1'b1;
        @(posedge clk); #2;

        // Bad checksum: writes still happen, error raised.
        wr_a.delete(); wr_d.delete();
        run_load(bad_q, 1'b0, -1);
        chk_two_words("bad");
        chk_flags("bad", 1'b0, 1'b1, 1'b1);

        // Stalled source (valid toggles), started from ERROR.
        wr_a.delete(); wr_d.delete();
        run_load(good_q, 1'b1, -1);
        chk_two_words("stall");
        chk_flags("stall", 1'b1, 1'b0, 1'b0);

        // start during HI is ignored.
        wr_a.delete(); wr_d.delete();
        run_load(good_q, 1'b0, 1);
        chk_two_words("starthi");
        chk_flags("starthi", 1'b1, 1'b0, 1'b0);

        // Reset between HI and LO of word 1.
        wr_a.delete(); wr_d.delete();
        run_load(part_q, 1'b0, -1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        chk("midrst_nwr", 32'(wr_a.size()), 32'd1);
        @(posedge clk); #2;
        wr_a.delete(); wr_d.delete();
        run_load(good_q, 1'b0, -1);
        chk_two_words("reload");
        chk_flags("reload", 1'b1, 1'b0, 1'b0);

        // Full-depth load: N=0 -> 256 words.
        full_q.delete();
        full_q.push_back(8'h00);
        x = 8'h00;
        for (int i = 0; i < 256; i++) begin
            hi_b = 8'(i * 3);
            lo_b = 8'(i) ^ 8'h5A;
            full_q.push_back(hi_b);
            full_q.push_back(lo_b);
            x = x ^ hi_b ^ lo_b;
        end
        full_q.push_back(x);
        wr_a.delete(); wr_d.delete();
        run_load(full_q, 1'b0, -1);
        chk("full_nwr", 32'(wr_a.size()), 32'd256);
        if (wr_a.size() == 256) begin
            for (int i = 0; i < 256; i++) begin
                chk("full_addr", 32'(wr_a[i]), 32'(i));
                chk("full_data", 32'(wr_d[i]), 32'({8'(i * 3), 8'(i) ^ 8'h5A}));
            end
        end
        chk("full_wrap", 32'(mem_addr), 32'd0);
        chk_flags("full", 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
